rob_alloc: RTL and testbench
============================

Name: rob_alloc

Overview:
- Issue-side counterpart of the reorder buffer. It hands out ROB slot indices in program order to the decode/issue stage.
- It tracks which allocated slots still await completion and counts occupancy from the allocations and the ROB's retirement pulses.
- It stalls issue when the ROB is full, and flushes in lockstep with the ROB `clear`.
- It sits between decode (requester), the three execution completion ports (observed snoop-only), and the ROB head (retire pulse).

Parameters:
- ROB_SLOTS, 16, number of ROB entries; must be a power of two and match proc.ROB_SLOTS.
- ROB_IDX_BITS, 4, log2(ROB_SLOTS); must match proc.ROB_IDX_BITS.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush (exception/mispredict); same effect as rst on state.
- allocReq  in  1  decode requests one slot this cycle.
- allocGrant  out  1  slot granted this cycle (combinational).
- allocIdx  out  ROB_IDX_BITS  index of the granted slot, equal to the tail pointer.
- cmpValid1, cmpValid2, cmpValid3  in  1 each  completion write to the ROB on port 1/2/3.
- cmpIdx1, cmpIdx2, cmpIdx3  in  ROB_IDX_BITS each  robIdx of that completion.
- retire  in  1  ROB head entry retired this cycle (ROB head valid).
- full  out  1  count == ROB_SLOTS.
- empty  out  1  count == 0.
- count  out  ROB_IDX_BITS+1  occupied slots, 0..ROB_SLOTS.
- pending  out  ROB_SLOTS  bit i = slot i allocated but not yet completed.
- protoErr  out  1  sticky protocol-violation flag.

Behaviour:
- State: tail, head (ROB_IDX_BITS each), count (ROB_IDX_BITS+1), pending bitmap, protoErr.
- Reset/clear (rst || clear at posedge):
  - tail=0, head=0, count=0, pending=0.
  - protoErr=0 on rst only; clear does not reset it.
  - Reset and clear override every other input that cycle.
- Outputs after reset: allocGrant=0, allocIdx=0, full=0, empty=1, count=0, pending=0, protoErr=0.
- Grant:
  - allocGrant = allocReq && !full && !clear && !rst. Purely combinational from registered count.
  - No same-cycle bypass of retire into full: at count==ROB_SLOTS with retire=1, the grant is still 0 and is given the next cycle.
- On grant:
  - tail <= (tail+1) mod ROB_SLOTS; natural wrap, 15 -> 0.
  - pending[tail] <= 1.
- On retire:
  - head <= (head+1) mod ROB_SLOTS.
  - If count==0, set protoErr and leave head/count unchanged.
- Count update: count <= count + grant - (retire && count!=0). Simultaneous grant and retire leaves count unchanged.
- Completions:
  - For each port k with cmpValidk=1: pending[cmpIdxk] <= 0.
  - If pending[cmpIdxk] is already 0, set protoErr (completion to an unallocated or already-completed slot).
  - If two ports in one cycle carry the same index, set protoErr; the clear still happens.
- Same-cycle grant and completion on the same slot: the grant wins and the bit ends at 1. A completion cannot legally precede allocation, so protoErr is set.
- Invariants:
  - count == (tail - head) mod ROB_SLOTS, except when full.
  - full implies tail == head.
- Latency:
  - Grant: 0 cycles (combinational).
  - Occupancy, pending and flags: visible 1 cycle after the event.

Decomposition:
- Package proc: ROB_SLOTS, ROB_IDX_BITS, plus an index typedef.
- One natural sub-module, rob_pending_bits: the ROB_SLOTS bitmap with one set port and three clear ports, plus duplicate/illegal-clear detection.

Test Plan:
- rst=1 for 2 cycles, then allocReq=1 for 3 cycles -> allocIdx 0,1,2 with allocGrant=1; count=3; pending=16'h0007; empty=0.
- Allocate 16 with no retire -> count=16, full=1. 17th request -> allocGrant=0 while allocIdx=0. retire=1 with allocReq=1 -> still no grant that cycle; next cycle grant with allocIdx=0, count=16.
- Fill 16, retire 4, allocate 4 -> indices 0,1,2,3 (wrap). Complete ports 1/2/3 with idx 5,6,7 in one cycle -> pending bits 5,6,7 clear together; protoErr=0.
- With 6 allocated, assert clear -> next cycle count=0, empty=1, pending=0, allocIdx=0. Any sticky protoErr remains set.
- Illegal cases -> protoErr=1 one cycle later: retire with count=0 (count stays 0); cmpValid1 with cmpIdx1=9 when pending[9]=0; cmpIdx2 = cmpIdx3 = 2 in the same cycle.
- Alloc and retire every cycle for 40 cycles from count=5 -> count constant 5; allocIdx sequence 5..15, 0..15, 0..12; no protoErr.

Source files
------------

// File: rtl/proc.sv
// Shared processor constants for the reorder-buffer slice: ROB geometry and
// the slot index / occupancy types used by issue-side logic.
package proc;

  localparam int ROB_SLOTS    = 16;
  localparam int ROB_IDX_BITS = 4;
  localparam int NUM_CMP      = 3;

  typedef logic [ROB_IDX_BITS-1:0] rob_idx_t;
  typedef logic [ROB_IDX_BITS:0]   rob_cnt_t;

endpackage

// File: rtl/rob_alloc_if.sv
// Decode-to-allocator handshake: one slot request per cycle, answered
// combinationally with a grant and the slot index.
interface rob_alloc_if #(
  parameter int IDX_BITS = proc::ROB_IDX_BITS
);
  import proc::*;

  logic                allocReq;
  logic                allocGrant;
  logic [IDX_BITS-1:0] allocIdx;

  modport master (output allocReq, input allocGrant, input allocIdx);
  modport slave  (input allocReq, output allocGrant, output allocIdx);

endinterface

// File: rtl/rob_pending_bits.sv
// Per-slot "allocated but not completed" bitmap with one set port and
// NUM_CLR clear ports; flags illegal or duplicate clears combinationally.
module rob_pending_bits #(
  parameter int ROB_SLOTS    = proc::ROB_SLOTS,
  parameter int ROB_IDX_BITS = proc::ROB_IDX_BITS,
  parameter int NUM_CLR      = proc::NUM_CMP
) (
  input  logic                                 clk,
  input  logic                                 flush,
  input  logic                                 set_en,
  input  logic [ROB_IDX_BITS-1:0]              set_idx,
  input  logic [NUM_CLR-1:0]                   clr_en,
  input  logic [NUM_CLR-1:0][ROB_IDX_BITS-1:0] clr_idx,
  output logic [ROB_SLOTS-1:0]                 pending,
  output logic                                 err
);
  import proc::*;

  logic [ROB_SLOTS-1:0] r_pending;
  logic [ROB_SLOTS-1:0] w_next;
  logic                 w_err;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    w_next = r_pending;
    w_err  = 1'b0;
    for (int k = 0; k < NUM_CLR; k++) begin
      if (clr_en[k]) begin
        w_next[clr_idx[k]] = 1'b0;
        if (!r_pending[clr_idx[k]]) w_err = 1'b1;
        // A completion cannot legally land on the slot being allocated now.
        if (set_en && (set_idx == clr_idx[k])) w_err = 1'b1;
        for (int j = k + 1; j < NUM_CLR; j++) begin
          if (clr_en[j] && (clr_idx[j] == clr_idx[k])) w_err = 1'b1;
        end
      end
    end
    // Set after the clears so a same-cycle grant wins.
    if (set_en) w_next[set_idx] = 1'b1;
  end

  // NOTE: this bitmap is reset (unlike a data RAM) because a flush must drop every pending slot.
  always_ff @(posedge clk) begin
    if (flush) r_pending <= '0;
    else       r_pending <= w_next;
  end

  assign pending = r_pending;
  assign err     = w_err;

endmodule

// File: rtl/rob_alloc.sv
// Issue-side ROB slot allocator: hands out tail indices in program order,
// tracks occupancy and pending completions, stalls on full, flushes on clear.
module rob_alloc #(
  parameter int ROB_SLOTS    = proc::ROB_SLOTS,
  parameter int ROB_IDX_BITS = proc::ROB_IDX_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  rob_alloc_if.slave              alloc,
  input  logic                    cmpValid1,
  input  logic                    cmpValid2,
  input  logic                    cmpValid3,
  input  logic [ROB_IDX_BITS-1:0] cmpIdx1,
  input  logic [ROB_IDX_BITS-1:0] cmpIdx2,
  input  logic [ROB_IDX_BITS-1:0] cmpIdx3,
  input  logic                    retire,
  output logic                    full,
  output logic                    empty,
  output logic [ROB_IDX_BITS:0]   count,
  output logic [ROB_SLOTS-1:0]    pending,
  output logic                    protoErr
);
  import proc::*;

  localparam int                  CW         = ROB_IDX_BITS + 1;
  localparam logic [CW-1:0]       FULL_COUNT = CW'(ROB_SLOTS);

  logic [ROB_IDX_BITS-1:0] r_tail;
  logic [ROB_IDX_BITS-1:0] r_head;
  logic [CW-1:0]           r_count;
  logic                    r_proto_err;

  logic w_flush;
  logic w_full;
  logic w_grant;
  logic w_retire_ok;
  logic w_retire_err;
  logic w_pend_err;

  assign w_flush      = rst || clear;
  assign w_full       = (r_count == FULL_COUNT);
  // Grant looks only at registered occupancy: a retire this cycle frees a slot next cycle.
  assign w_grant      = alloc.allocReq && !w_full && !w_flush;
  assign w_retire_ok  = retire && (r_count != '0);
  assign w_retire_err = retire && (r_count == '0);

  rob_pending_bits #(
    .ROB_SLOTS    (ROB_SLOTS),
    .ROB_IDX_BITS (ROB_IDX_BITS),
    .NUM_CLR      (3)
  ) u_pending (
    .clk     (clk),
    .flush   (w_flush),
    .set_en  (w_grant),
    .set_idx (r_tail),
    .clr_en  ({cmpValid3, cmpValid2, cmpValid1}),
    .clr_idx ({cmpIdx3, cmpIdx2, cmpIdx1}),
    .pending (pending),
    .err     (w_pend_err)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_tail  <= '0;
      r_head  <= '0;
      r_count <= '0;
      // The error flag survives a pipeline flush; only a true reset clears it.
      if (rst) r_proto_err <= 1'b0;
    end else begin
      if (w_grant)     r_tail <= r_tail + 1'b1;
      if (w_retire_ok) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_grant) - CW'(w_retire_ok);
      if (w_retire_err || w_pend_err) r_proto_err <= 1'b1;
    end
  end

  assign alloc.allocGrant = w_grant;
  assign alloc.allocIdx   = r_tail;
  assign full             = w_full;
  assign empty            = (r_count == '0);
  assign count            = r_count;
  assign protoErr         = r_proto_err;

endmodule

// File: tb/tb_rob_alloc.sv
// Scoreboard bench for rob_alloc: a queue-based occupancy model predicts each
// cycle's outputs; a negedge monitor pops and compares them independently.
module tb_rob_alloc;
  import proc::*;

  localparam int N = ROB_SLOTS;

  logic                  clk = 1'b0;
  logic                  rst, clear, retire;
  logic                  cmpValid1, cmpValid2, cmpValid3;
  rob_idx_t              cmpIdx1, cmpIdx2, cmpIdx3;
  logic                  full, empty, protoErr;
  logic [ROB_IDX_BITS:0] count;
  logic [N-1:0]          pending;

  rob_alloc_if u_if ();

  always #5 clk = ~clk;

  rob_alloc u_dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .alloc     (u_if),
    .cmpValid1 (cmpValid1),
    .cmpValid2 (cmpValid2),
    .cmpValid3 (cmpValid3),
    .cmpIdx1   (cmpIdx1),
    .cmpIdx2   (cmpIdx2),
    .cmpIdx3   (cmpIdx3),
    .retire    (retire),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .pending   (pending),
    .protoErr  (protoErr)
  );

  typedef struct packed {
    logic                      req;
    logic                      ret;
    logic                      clr;
    logic                      rs;
    logic [2:0]                cv;
    logic [2:0][ROB_IDX_BITS-1:0] ci;
  } stim_t;

  typedef struct packed {
    logic                  grant;
    logic [ROB_IDX_BITS-1:0] idx;
    logic [ROB_IDX_BITS:0] cnt;
    logic                  full;
    logic                  empty;
    logic [N-1:0]          pend;
    logic                  perr;
  } exp_t;

  exp_t exp_q[$];
  int   idx_q[$];

  // Reference model: the ROB contents as an ordered list of slot numbers.
  int rob_q[$];
  int next_idx;
  bit pend_m[N];
  bit perr_m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = pend_m[i];
    return v;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic model_update(input stim_t s, input bit g);
    if (s.rs || s.clr) begin
      rob_q.delete();
      next_idx = 0;
      for (int i = 0; i < N; i++) pend_m[i] = 1'b0;
      if (s.rs) perr_m = 1'b0;
      return;
    end
    if (s.ret && rob_q.size() == 0) perr_m = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (s.cv[k]) begin
        if (!pend_m[int'(s.ci[k])]) perr_m = 1'b1;
        if (g && int'(s.ci[k]) == next_idx) perr_m = 1'b1;
        for (int j = k + 1; j < 3; j++)
          if (s.cv[j] && s.ci[j] == s.ci[k]) perr_m = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++)
      if (s.cv[k]) pend_m[int'(s.ci[k])] = 1'b0;
    if (s.ret && rob_q.size() > 0) void'(rob_q.pop_front());
    if (g) begin
      rob_q.push_back(next_idx);
      pend_m[next_idx] = 1'b1;
      next_idx = (next_idx + 1) % N;
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    u_if.allocReq = s.req;
    retire        = s.ret;
    clear         = s.clr;
    rst           = s.rs;
    cmpValid1     = s.cv[0];
    cmpValid2     = s.cv[1];
    cmpValid3     = s.cv[2];
    cmpIdx1       = s.ci[0];
    cmpIdx2       = s.ci[1];
    cmpIdx3       = s.ci[2];
    e.grant = s.req && (rob_q.size() < N) && !s.clr && !s.rs;
    e.idx   = rob_idx_t'(next_idx);
    e.cnt   = (ROB_IDX_BITS + 1)'(rob_q.size());
    e.full  = (rob_q.size() == N);
    e.empty = (rob_q.size() == 0);
    e.pend  = pend_vec();
    e.perr  = perr_m;
    exp_q.push_back(e);
    if (e.grant) idx_q.push_back(next_idx);
    @(posedge clk);
    model_update(s, e.grant);
    #1;
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest prediction.
  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      check("allocGrant", 32'(u_if.allocGrant), 32'(me.grant));
      check("allocIdx",   32'(u_if.allocIdx),   32'(me.idx));
      check("count",      32'(count),           32'(me.cnt));
      check("full",       32'(full),            32'(me.full));
      check("empty",      32'(empty),           32'(me.empty));
      check("pending",    32'(pending),         32'(me.pend));
      check("protoErr",   32'(protoErr),        32'(me.perr));
      if (u_if.allocGrant === 1'b1) begin
        if (idx_q.size() == 0) check("grant_unexpected", 32'(u_if.allocGrant), 32'd0);
        else                   check("granted_idx", 32'(u_if.allocIdx), 32'(idx_q.pop_front()));
      end
    end
  end

  initial begin
    stim_t s;
    int    cand[$];
    int    pick;

    u_if.allocReq = 1'b0;
    rst = 1'b1; clear = 1'b0; retire = 1'b0;
    cmpValid1 = 1'b0; cmpValid2 = 1'b0; cmpValid3 = 1'b0;
    cmpIdx1 = '0; cmpIdx2 = '0; cmpIdx3 = '0;
    next_idx = 0; perr_m = 1'b0;
    for (int i = 0; i < N; i++) pend_m[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then three allocations.
    s = idle(); s.rs = 1'b1; step(s);
    s = idle(); s.req = 1'b1; repeat (3) step(s);
    // Fill to 16, overflow request, retire while full, then wrap grant.
    repeat (13) step(s);
    step(s);
    s.ret = 1'b1; step(s);
    s.ret = 1'b0; step(s);
    s = idle(); step(s);

    // Fill, retire 4, allocate 4 (wrap), triple completion 5/6/7.
    s = idle(); s.rs = 1'b1; step(s);
    s = idle(); s.req = 1'b1; repeat (16) step(s);
    s = idle(); s.ret = 1'b1; repeat (4) step(s);
    s = idle(); s.req = 1'b1; repeat (4) step(s);
    s = idle(); s.cv = 3'b111; s.ci[0] = 4'd5; s.ci[1] = 4'd6; s.ci[2] = 4'd7; step(s);
    s = idle(); step(s);

    // Illegal completion to idle slot 9, then clear keeps the sticky flag.
    s = idle(); s.rs = 1'b1; step(s);
    s = idle(); s.req = 1'b1; repeat (6) step(s);
    s = idle(); s.cv[0] = 1'b1; s.ci[0] = 4'd9; step(s);
    s = idle(); step(s);
    s = idle(); s.clr = 1'b1; step(s);
    s = idle(); repeat (2) step(s);

    // Retire when empty.
    s = idle(); s.rs = 1'b1; step(s);
    s = idle(); s.ret = 1'b1; step(s);
    s = idle(); repeat (2) step(s);

    // Duplicate completion index on ports 2 and 3.
    s = idle(); s.rs = 1'b1; step(s);
    s = idle(); s.req = 1'b1; repeat (3) step(s);
    s = idle(); s.cv = 3'b110; s.ci[1] = 4'd2; s.ci[2] = 4'd2; step(s);
    s = idle(); step(s);

    // Grant and completion on the same slot in one cycle.
    s = idle(); s.rs = 1'b1; step(s);
    s = idle(); s.req = 1'b1; repeat (2) step(s);
    s.cv[0] = 1'b1; s.ci[0] = 4'd2; step(s);
    s = idle(); step(s);

    // Clear overrides a request, a retire and an illegal completion.
    s = idle(); s.rs = 1'b1; step(s);
    s = idle(); s.req = 1'b1; repeat (2) step(s);
    s = idle(); s.clr = 1'b1; s.req = 1'b1; s.ret = 1'b1; s.cv[0] = 1'b1; s.ci[0] = 4'd9; step(s);
    s = idle(); step(s);

    // Steady alloc+retire from count 5 for 40 cycles.
    s = idle(); s.rs = 1'b1; step(s);
    s = idle(); s.req = 1'b1; repeat (5) step(s);
    s.ret = 1'b1; repeat (40) step(s);
    s = idle(); step(s);

    // Randomised traffic: mostly legal completions, occasional faults and flushes.
    s = idle(); s.rs = 1'b1; step(s);
    for (int c = 0; c < 400; c++) begin
      s = idle();
      s.req = ($urandom_range(0, 99) < 60);
      s.ret = (rob_q.size() > 0) && ($urandom_range(0, 99) < 45);
      cand.delete();
      for (int i = 0; i < N; i++) if (pend_m[i]) cand.push_back(i);
      for (int k = 0; k < 3; k++) begin
        if (cand.size() > 0 && $urandom_range(0, 99) < 30) begin
          pick = $urandom_range(0, cand.size() - 1);
          s.cv[k] = 1'b1;
          s.ci[k] = rob_idx_t'(cand[pick]);
          cand.delete(pick);
        end
      end
      pick = $urandom_range(0, 99);
      if (pick < 2) s.rs = 1'b1;
      else if (pick < 5) s.clr = 1'b1;
      else if (pick < 8) begin
        s.cv[0] = 1'b1;
        s.ci[0] = rob_idx_t'($urandom_range(0, N - 1));
        s.ret   = 1'b1;
      end
      step(s);
    end

    s = idle(); repeat (2) step(s);
    @(negedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("idx_q_drained", 32'(idx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
